// File: rtl/cg_iteration_sequencer.sv
// Central controller for one conjugate-gradient solve: sequences the ALU stages, issues
// go pulses and vector read strobes, captures rsold/rsnew and checks convergence.
module cg_iteration_sequencer #(
  parameter int unsigned              element_width  = 32,
  parameter int unsigned              no_of_units    = 8,
  parameter int unsigned              max_iterations = 1024,
  parameter logic [element_width-1:0] tolerance      = 32'h283424DC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [31:0]              total,
  input  logic                     rd_ready,
  input  logic                     vxv1_done,
  input  logic                     vxv3_done,
  input  logic [element_width-1:0] vxv1_result,
  input  logic [element_width-1:0] vxv3_result,
  input  logic                     mxv_done,
  input  logic                     div1_done,
  input  logic                     div2_done,
  input  logic                     muladd_x_done,
  input  logic                     muladd_r_done,
  input  logic                     muladd_p_done,
  output logic                     vxv1_go,
  output logic                     mxv_go,
  output logic                     div1_go,
  output logic                     muladd_xr_go,
  output logic                     vxv3_go,
  output logic                     div2_go,
  output logic                     muladd_p_go,
  output logic                     rd_strobe,
  output logic [element_width-1:0] rold,
  output logic [element_width-1:0] rnew,
  output logic [31:0]              iteration_count,
  output logic                     busy,
  output logic                     converged,
  output logic                     timeout,
  output logic                     finish_all
);

  localparam int unsigned BeatShift = $clog2(no_of_units);
  localparam logic [31:0] MinTotal  = 32'(no_of_units);
  localparam logic [31:0] MaxIter   = 32'(max_iterations);

  typedef enum logic [3:0] {
    StIdle, StRrOld, StMxv, StDivAlpha, StUpdXr, StRrNew, StCheck, StDivBeta, StUpdP, StDone
  } state_e;

  state_e                   state_q, state_d;
  logic                     entry_q, entry_d;
  logic [31:0]              beats_q, beats_d;
  logic [31:0]              beat_q, beat_d;
  logic [element_width-1:0] rold_q, rold_d;
  logic [element_width-1:0] rnew_q, rnew_d;
  logic [31:0]              iter_q, iter_d;
  logic                     conv_q, conv_d;
  logic                     tmo_q, tmo_d;
  logic                     x_seen_q, x_seen_d;
  logic                     r_seen_q, r_seen_d;
  logic                     vxv1_go_q, vxv1_go_d;
  logic                     mxv_go_q, mxv_go_d;
  logic                     div1_go_q, div1_go_d;
  logic                     xr_go_q, xr_go_d;
  logic                     vxv3_go_q, vxv3_go_d;
  logic                     div2_go_q, div2_go_d;
  logic                     p_go_q, p_go_d;
  logic                     armed;
  logic                     rr_done;

  always_comb begin
    state_d   = state_q;
    beats_d   = beats_q;
    beat_d    = beat_q;
    rold_d    = rold_q;
    rnew_d    = rnew_q;
    iter_d    = iter_q;
    conv_d    = conv_q;
    tmo_d     = tmo_q;
    x_seen_d  = x_seen_q;
    r_seen_d  = r_seen_q;
    rd_strobe = 1'b0;
    // Dones are only honoured once the state's entry cycle has passed.
    armed     = !entry_q;
    rr_done   = armed && (beat_q == beats_q);

    unique case (state_q)
      StIdle: begin
        if (start && (total >= MinTotal)) begin
          beats_d = total >> BeatShift;
          iter_d  = '0;
          conv_d  = 1'b0;
          tmo_d   = 1'b0;
          state_d = StRrOld;
        end
      end
      StRrOld, StRrNew: begin
        rd_strobe = armed && rd_ready && (beat_q < beats_q);
        if (rd_strobe) beat_d = beat_q + 32'd1;
        if (state_q == StRrOld && rr_done && vxv1_done) begin
          rold_d  = vxv1_result;
          state_d = StMxv;
        end else if (state_q == StRrNew && rr_done && vxv3_done) begin
          rnew_d  = vxv3_result;
          state_d = StCheck;
        end
      end
      StMxv:      if (armed && mxv_done)  state_d = StDivAlpha;
      StDivAlpha: if (armed && div1_done) state_d = StUpdXr;
      StUpdXr: begin
        if (armed) begin
          x_seen_d = x_seen_q | muladd_x_done;
          r_seen_d = r_seen_q | muladd_r_done;
          if (x_seen_d && r_seen_d) begin
            x_seen_d = 1'b0;
            r_seen_d = 1'b0;
            state_d  = StRrNew;
          end
        end
      end
      StCheck: begin
        iter_d = iter_q + 32'd1;
        // rsnew is a sum of squares, so the sign bit carries no information.
        if (rnew_q[element_width-2:0] <= tolerance[element_width-2:0]) begin
          conv_d  = 1'b1;
          state_d = StDone;
        end else if (iter_q + 32'd1 == MaxIter) begin
          tmo_d   = 1'b1;
          state_d = StDone;
        end else begin
          rold_d  = rnew_q;
          state_d = StDivBeta;
        end
      end
      StDivBeta: if (armed && div2_done)     state_d = StUpdP;
      StUpdP:    if (armed && muladd_p_done) state_d = StMxv;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    entry_d = (state_d != state_q);
    if (entry_d) beat_d = '0;

    vxv1_go_d = entry_q && (state_q == StRrOld);
    mxv_go_d  = entry_q && (state_q == StMxv);
    div1_go_d = entry_q && (state_q == StDivAlpha);
    xr_go_d   = entry_q && (state_q == StUpdXr);
    vxv3_go_d = entry_q && (state_q == StRrNew);
    div2_go_d = entry_q && (state_q == StDivBeta);
    p_go_d    = entry_q && (state_q == StUpdP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      entry_q   <= 1'b0;
      beats_q   <= '0;
      beat_q    <= '0;
      rold_q    <= '0;
      rnew_q    <= '0;
      iter_q    <= '0;
      conv_q    <= 1'b0;
      tmo_q     <= 1'b0;
      x_seen_q  <= 1'b0;
      r_seen_q  <= 1'b0;
      vxv1_go_q <= 1'b0;
      mxv_go_q  <= 1'b0;
      div1_go_q <= 1'b0;
      xr_go_q   <= 1'b0;
      vxv3_go_q <= 1'b0;
      div2_go_q <= 1'b0;
      p_go_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      beats_q   <= beats_d;
      beat_q    <= beat_d;
      rold_q    <= rold_d;
      rnew_q    <= rnew_d;
      iter_q    <= iter_d;
      conv_q    <= conv_d;
      tmo_q     <= tmo_d;
      x_seen_q  <= x_seen_d;
      r_seen_q  <= r_seen_d;
      vxv1_go_q <= vxv1_go_d;
      mxv_go_q  <= mxv_go_d;
      div1_go_q <= div1_go_d;
      xr_go_q   <= xr_go_d;
      vxv3_go_q <= vxv3_go_d;
      div2_go_q <= div2_go_d;
      p_go_q    <= p_go_d;
    end
  end

  assign vxv1_go         = vxv1_go_q;
  assign mxv_go          = mxv_go_q;
  assign div1_go         = div1_go_q;
  assign muladd_xr_go    = xr_go_q;
  assign vxv3_go         = vxv3_go_q;
  assign div2_go         = div2_go_q;
  assign muladd_p_go     = p_go_q;
  assign rold            = rold_q;
  assign rnew            = rnew_q;
  assign iteration_count = iter_q;
  assign busy            = (state_q != StIdle);
  assign converged       = conv_q;
  assign timeout         = tmo_q;
  assign finish_all      = (state_q == StDone);

endmodule

// File: tb/tb_cg_iteration_sequencer.sv
// Directed bench for cg_iteration_sequencer: a stage responder model answers go pulses,
// a vector table drives whole solves, and hand sequences cover reset and ignored starts.
module tb_cg_iteration_sequencer;

  logic        clk, reset, start, rd_ready;
  logic [31:0] total;
  logic        vxv1_done, vxv3_done, mxv_done, div1_done, div2_done;
  logic        muladd_x_done, muladd_r_done, muladd_p_done;
  logic [31:0] vxv1_result, vxv3_result;
  logic        vxv1_go, mxv_go, div1_go, muladd_xr_go, vxv3_go, div2_go, muladd_p_go;
  logic        rd_strobe, busy, converged, timeout, finish_all;
  logic [31:0] rold, rnew, iteration_count;

  cg_iteration_sequencer #(.max_iterations(3)) dut (
    .clk(clk), .reset(reset), .start(start), .total(total), .rd_ready(rd_ready),
    .vxv1_done(vxv1_done), .vxv3_done(vxv3_done),
    .vxv1_result(vxv1_result), .vxv3_result(vxv3_result),
    .mxv_done(mxv_done), .div1_done(div1_done), .div2_done(div2_done),
    .muladd_x_done(muladd_x_done), .muladd_r_done(muladd_r_done),
    .muladd_p_done(muladd_p_done),
    .vxv1_go(vxv1_go), .mxv_go(mxv_go), .div1_go(div1_go), .muladd_xr_go(muladd_xr_go),
    .vxv3_go(vxv3_go), .div2_go(div2_go), .muladd_p_go(muladd_p_go),
    .rd_strobe(rd_strobe), .rold(rold), .rnew(rnew), .iteration_count(iteration_count),
    .busy(busy), .converged(converged), .timeout(timeout), .finish_all(finish_all)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] total;
    bit          toggle, conv, stagger, early, poke;
    int          strobes, v1, v3, mxv, d2, xr, iters;
    bit          exp_conv, exp_tmo;
    logic [31:0] exp_rold, exp_rnew;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Settings for the responder, written by the main sequence only.
  int cur_beats = 4;
  bit cur_toggle, cur_conv, cur_stagger, cur_early;
  int clr_seq = 0;

  // Responder state and observation counters.
  int cyc, seen_seq;
  int n_strobe, n_bad, n_v1, n_v3, n_mxv, n_d2, n_xr, n_fin;
  int rr_cnt, rr_which, t_rr, t_mxv, t_d1, t_x, t_r, t_d2, t_p;
  int x_cyc, r_cyc, g3_cyc;
  bit rr_active;

  function automatic bit tick(inout int t);
    if (t > 0) begin
      t--;
      return (t == 0);
    end
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Stage model: each stage answers 3 cycles after its go; r.r stages answer 3 cycles
  // after their last read beat. Inputs change on the falling edge.
  initial begin
    vxv1_done = 0; vxv3_done = 0; mxv_done = 0; div1_done = 0; div2_done = 0;
    muladd_x_done = 0; muladd_r_done = 0; muladd_p_done = 0;
    vxv1_result = 32'h41200000; vxv3_result = 32'h3F800000; rd_ready = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (clr_seq != seen_seq) begin
        seen_seq = clr_seq;
        n_strobe = 0; n_bad = 0; n_v1 = 0; n_v3 = 0; n_mxv = 0; n_d2 = 0; n_xr = 0;
        n_fin = 0; rr_cnt = 0; rr_which = 0; rr_active = 0;
        t_rr = 0; t_mxv = 0; t_d1 = 0; t_x = 0; t_r = 0; t_d2 = 0; t_p = 0;
        x_cyc = 0; r_cyc = 0; g3_cyc = 0;
        rd_ready = 1'b1;
      end
      vxv1_done = 0; vxv3_done = 0; mxv_done = 0; div1_done = 0; div2_done = 0;
      muladd_x_done = 0; muladd_r_done = 0; muladd_p_done = 0;
      if (tick(t_rr)) begin
        if (rr_which == 1) vxv1_done = 1'b1;
        else vxv3_done = 1'b1;
      end
      if (tick(t_mxv)) mxv_done = 1'b1;
      if (tick(t_d1)) div1_done = 1'b1;
      if (tick(t_x)) begin
        muladd_x_done = 1'b1;
        if (n_xr == 1) x_cyc = cyc;
      end
      if (tick(t_r)) begin
        muladd_r_done = 1'b1;
        if (n_xr == 1) r_cyc = cyc;
      end
      if (tick(t_d2)) div2_done = 1'b1;
      if (tick(t_p)) muladd_p_done = 1'b1;

      if (vxv1_go) begin
        n_v1++; rr_which = 1; rr_cnt = 0; rr_active = 1;
      end
      if (vxv3_go) begin
        n_v3++; rr_which = 3; rr_cnt = 0; rr_active = 1;
        vxv3_result = (cur_conv && n_v3 == 1) ? 32'h20000000 : 32'h3F800000;
        if (n_v3 == 1) g3_cyc = cyc;
      end
      if (rd_strobe) begin
        n_strobe++;
        if (!rd_ready) n_bad++;
        if (rr_active) begin
          rr_cnt++;
          if (rr_cnt == cur_beats) begin
            rr_active = 0;
            t_rr = 3;
          end else if (cur_early && rr_which == 1 && rr_cnt == 5) begin
            vxv1_done = 1'b1;
          end
        end
      end
      if (mxv_go) begin n_mxv++; t_mxv = 3; end
      if (div1_go) t_d1 = 3;
      if (muladd_xr_go) begin
        n_xr++;
        if (cur_stagger && n_xr == 1) begin t_r = 3; t_x = 8; end
        else begin t_r = 3; t_x = 3; end
      end
      if (div2_go) begin n_d2++; t_d2 = 3; end
      if (muladd_p_go) t_p = 3;
      if (finish_all) n_fin++;
      rd_ready = cur_toggle ? !rd_ready : 1'b1;
    end
  end

  task automatic setup(input vec_t v);
    @(negedge clk);
    #1;
    cur_beats   = int'(v.total >> 3);
    cur_toggle  = v.toggle;
    cur_conv    = v.conv;
    cur_stagger = v.stagger;
    cur_early   = v.early;
    clr_seq++;
    @(negedge clk);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit seen;
    int last;
    setup(v);
    #1;
    total = v.total;
    start = 1'b1;
    @(negedge clk);
    check($sformatf("v%0d_busy_after_start", idx), {31'd0, busy}, 32'd1);
    check($sformatf("v%0d_go_not_yet", idx), {31'd0, vxv1_go}, 32'd0);
    #1 start = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_go_latency", idx), {31'd0, vxv1_go}, 32'd1);
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (finish_all) begin
        seen = 1;
        break;
      end
      if (v.poke && i == 20) begin #1 start = 1'b1; total = 32'd64; end
      if (v.poke && i == 21) begin #1 start = 1'b0; total = v.total; end
    end
    check($sformatf("v%0d_finish_seen", idx), {31'd0, seen}, 32'd1);
    @(negedge clk);
    check($sformatf("v%0d_finish_one_cycle", idx), {30'd0, finish_all, busy}, 32'd0);
    repeat (2) @(negedge clk);
    last = (x_cyc > r_cyc) ? x_cyc : r_cyc;
    check($sformatf("v%0d_strobes", idx), n_strobe, v.strobes);
    check($sformatf("v%0d_strobe_not_ready", idx), n_bad, 0);
    check($sformatf("v%0d_vxv1_go", idx), n_v1, v.v1);
    check($sformatf("v%0d_vxv3_go", idx), n_v3, v.v3);
    check($sformatf("v%0d_mxv_go", idx), n_mxv, v.mxv);
    check($sformatf("v%0d_div2_go", idx), n_d2, v.d2);
    check($sformatf("v%0d_xr_go", idx), n_xr, v.xr);
    check($sformatf("v%0d_finish_pulses", idx), n_fin, 1);
    check($sformatf("v%0d_xr_exit_gap", idx), g3_cyc - last, 2);
    check($sformatf("v%0d_iterations", idx), iteration_count, v.iters);
    check($sformatf("v%0d_converged", idx), {31'd0, converged}, {31'd0, v.exp_conv});
    check($sformatf("v%0d_timeout", idx), {31'd0, timeout}, {31'd0, v.exp_tmo});
    check($sformatf("v%0d_rold", idx), rold, v.exp_rold);
    check($sformatf("v%0d_rnew", idx), rnew, v.exp_rnew);
  endtask

  vec_t vecs[7];

  initial begin
    bit seen;
    vecs[0] = '{32'd32, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8, 1, 1, 1, 0, 1, 1,
                1'b1, 1'b0, 32'h41200000, 32'h20000000};
    vecs[1] = '{32'd32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16, 1, 3, 3, 2, 3, 3,
                1'b0, 1'b1, 32'h3F800000, 32'h3F800000};
    vecs[2] = '{32'd64, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16, 1, 1, 1, 0, 1, 1,
                1'b1, 1'b0, 32'h41200000, 32'h20000000};
    vecs[3] = '{32'd32, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16, 1, 3, 3, 2, 3, 3,
                1'b0, 1'b1, 32'h3F800000, 32'h3F800000};
    vecs[4] = '{32'd16, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4, 1, 1, 1, 0, 1, 1,
                1'b1, 1'b0, 32'h41200000, 32'h20000000};
    vecs[5] = '{32'd40, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10, 1, 1, 1, 0, 1, 1,
                1'b1, 1'b0, 32'h41200000, 32'h20000000};
    vecs[6] = '{32'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1, 3, 3, 2, 3, 3,
                1'b0, 1'b1, 32'h3F800000, 32'h3F800000};

    reset = 1'b1;
    start = 1'b0;
    total = '0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_status", {28'd0, busy, converged, timeout, finish_all}, 32'd0);
    check("reset_go_strobe", {24'd0, vxv1_go, mxv_go, div1_go, muladd_xr_go, vxv3_go,
                              div2_go, muladd_p_go, rd_strobe}, 32'd0);
    check("reset_rold", rold, 32'd0);
    check("reset_rnew", rnew, 32'd0);
    check("reset_iterations", iteration_count, 32'd0);

    // Too-short vector: start must be ignored.
    setup(vecs[0]);
    #1;
    total = 32'd4;
    start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("short_start_idle", {31'd0, busy}, 32'd0);
    end
    check("short_start_no_go", n_v1, 0);

    // Reset while waiting on the A.p stage.
    setup(vecs[0]);
    #1;
    total = 32'd32;
    start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mxv_go) begin
        seen = 1;
        break;
      end
    end
    check("mxv_reached", {31'd0, seen}, 32'd1);
    #1 reset = 1'b1;
    @(negedge clk);
    check("midreset_status", {28'd0, busy, converged, timeout, finish_all}, 32'd0);
    check("midreset_rold", rold, 32'd0);
    check("midreset_iterations", iteration_count, 32'd0);
    #1 reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("midreset_quiet", {23'd0, busy, vxv1_go, mxv_go, div1_go, muladd_xr_go,
                               vxv3_go, div2_go, muladd_p_go, rd_strobe}, 32'd0);
    end

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
